// File: rtl/mem_resp_pkg.sv
// Shared definitions for the backing-memory responder and its cache-side users.
package mem_resp_pkg;

    localparam int unsigned WORD_ADDR_W    = 30;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_LATENCY    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } resp_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the data cache (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [WORD_ADDR_W-1:0] req_addr;
    logic [31:0]            req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_data;
    logic                   rsp_last;
    logic                   rsp_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_write
    );

endinterface

// File: rtl/resp_mem_array.sv
// Word storage for the responder: combinational read port, clocked write port, no reset.
module resp_mem_array #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Latency-modelling memory responder: line-read bursts and single-word write acks.
// MEM_RESP_CRIT_WORD_FIRST_EN: start read bursts at the requested word, wrapping within the line.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

    resp_state_e   state;
    logic [CW-1:0] lat_cnt;
    logic [OW-1:0] beat;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [31:0]   wdata_q;

    logic [OW-1:0] line_off;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          wait_done;
    logic          mem_we;
    logic          addr_hi_unused;

    // Addresses above MEM_WORDS alias silently; the high bits are simply dropped.
    assign addr_hi_unused = ^bus.req_addr[WORD_ADDR_W-1:AW];

    assign wait_done = (state == WAIT) && (lat_cnt == '0);
    assign mem_we    = wait_done && write_q;

`ifdef MEM_RESP_CRIT_WORD_FIRST_EN
    assign line_off = addr_q[OW-1:0] + beat;
`else
    assign line_off = beat;
`endif
    assign rd_addr = {addr_q[AW-1:OW], line_off};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr[AW-1:0];
                        write_q <= bus.req_write;
                        wdata_q <= bus.req_wdata;
                        lat_cnt <= CW'(LATENCY - 1);
                        beat    <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= write_q ? WACK : BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                BURST: begin
                    if (bus.rsp_ready) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                WACK: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Outputs decode from registered state only, so they hold under backpressure.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == BURST) || (state == WACK);
    assign bus.rsp_write = (state == WACK);
    assign bus.rsp_last  = (state == WACK) || ((state == BURST) && (beat == LAST_BEAT));
    assign bus.rsp_data  = (state == BURST) ? rd_data : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (honours MEM_RESP_CRIT_WORD_FIRST_EN).
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LATENCY    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] model [int unsigned];

    mem_responder_if bus ();

    mem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .LINE_WORDS (LINE_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned beat_idx(input int unsigned a, input int unsigned k);
        int unsigned w;
        int unsigned base;
        w    = a % MEM_WORDS;
        base = w - (w % LINE_WORDS);
`ifdef MEM_RESP_CRIT_WORD_FIRST_EN
        return base + (((w % LINE_WORDS) + k) % LINE_WORDS);
`else
        return base + k;
`endif
    endfunction

    // Drive one request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [29:0] a, input logic [31:0] d);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("req_ready_wait", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic wait_first(input string tag);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LATENCY));
    endtask

    task automatic burst(input int unsigned a, input int stall_beat, input int stall_n,
                         input string tag);
        logic [31:0] exp;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < LINE_WORDS; k++) begin
            exp = model[beat_idx(a, k)];
            check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_data"},  bus.rsp_data, exp);
            check({tag, "_last"},  32'(bus.rsp_last), (k == LINE_WORDS - 1) ? 32'd1 : 32'd0);
            check({tag, "_write"}, 32'(bus.rsp_write), 32'd0);
            if (k == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.rsp_ready = 1'b0;
                    @(negedge clk);
                    check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                    check({tag, "_hold_data"},  bus.rsp_data, exp);
                    check({tag, "_hold_last"},  32'(bus.rsp_last), 32'd0);
                end
                bus.rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_end_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_end_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic write_word(input logic [29:0] a, input logic [31:0] d, input string tag);
        bus.rsp_ready = 1'b1;
        issue(1'b1, a, d);
        wait_first(tag);
        check({tag, "_ack_write"}, 32'(bus.rsp_write), 32'd1);
        check({tag, "_ack_last"},  32'(bus.rsp_last), 32'd1);
        check({tag, "_ack_data"},  bus.rsp_data, 32'd0);
        @(negedge clk);
        model[a % MEM_WORDS] = d;
        check({tag, "_ack_done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_last",  32'(bus.rsp_last),  32'd0);
        check("rst_rsp_write", 32'(bus.rsp_write), 32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            write_word(30'(32'h40 + i), 32'hA0 + 32'(i), "pre40");
        end
        for (int i = 1; i < 4; i++) begin
            write_word(30'(32'h80 + i), 32'hB0 + 32'(i), "pre80");
        end

        // Plain line read from the middle of a line.
        issue(1'b0, 30'h41, '0);
        wait_first("rd41");
        burst(32'h41, -1, 0, "rd41");

        // Write then read the same line.
        write_word(30'h80, 32'hDEADBEEF, "wr80");
        issue(1'b0, 30'h80, '0);
        wait_first("rd80");
        burst(32'h80, -1, 0, "rd80");

        // Two cycles of backpressure on beat 1.
        issue(1'b0, 30'h41, '0);
        wait_first("bp");
        burst(32'h41, 1, 2, "bp");

        // Second request held during a busy read, using an aliased address.
        issue(1'b0, 30'h41, '0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 30'(MEM_WORDS + 32'h41);
        wait_first("busy1");
        check("busy_ready_low", 32'(bus.req_ready), 32'd0);
        burst(32'h41, -1, 0, "busy1");
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("busy_accepted", 32'(bus.req_ready), 32'd0);
        wait_first("alias");
        burst(MEM_WORDS + 32'h41, -1, 0, "alias");

        // Reset in the middle of a burst, on beat 2.
        issue(1'b0, 30'h41, '0);
        wait_first("rstb");
        @(negedge clk);
        @(negedge clk);
        check("rstb_beat2", bus.rsp_data, model[beat_idx(32'h41, 2)]);
        rst = 1'b0;
        #1;
        check("rstb_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstb_ready", 32'(bus.req_ready), 32'd1);
        check("rstb_last",  32'(bus.rsp_last),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstb_quiet", 32'(bus.rsp_valid), 32'd0);
        end

        // Reset while a write is still waiting: the word must keep its old value.
        issue(1'b1, 30'h42, 32'h12345678);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 30'h40, '0);
        wait_first("rstw");
        burst(32'h40, -1, 0, "rstw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Backing-memory responder for the data cache: the target end of the cache's refill/write-through interface.
- Accepts one request at a time over a valid/ready handshake, waits a programmable latency, then:
  - read: returns a full cache line as a burst of word beats;
  - write: commits one word and returns a single acknowledge beat.
- Sits between `cache` and the memory system.
- Replaces the combinational `data_mem` backing path so miss and stall handling can be exercised with realistic latency.

Parameters:
- MEM_WORDS, 1024, storage depth in 32-bit words; power of two.
- LINE_WORDS, 4, words per refill burst; power of two, at least 2.
- LATENCY, 3, cycles from request acceptance to first response beat; at least 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = word write, 0 = line read
- req_addr  input  30  word address (byte address bits [31:2])
- req_wdata  input  32  write data
- rsp_valid  output  1  response beat present
- rsp_ready  input  1  requester accepts beat
- rsp_data  output  32  read data; 0 on write acknowledge
- rsp_last  output  1  final beat of the response
- rsp_write  output  1  beat is a write acknowledge

Behaviour:
- States: IDLE, WAIT, BURST, WACK.
- Reset (rst=0), asynchronous, regardless of state:
  - state=IDLE, beat and latency counters 0;
  - rsp_valid=0, rsp_last=0, rsp_write=0, rsp_data=0;
  - req_ready=1 (decoded from IDLE);
  - memory contents are not reset.
- IDLE:
  - req_ready=1; a request is accepted on the edge where req_valid and req_ready are both 1.
  - On acceptance, capture addr/write/wdata, load latency counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When the counter is 0: read goes to BURST, write goes to WACK.
  - A write commits mem[addr mod MEM_WORDS] on the edge leaving WAIT.
- Response timing: first rsp_valid is high exactly LATENCY cycles after the acceptance edge.
- BURST:
  - base = addr with low log2(LINE_WORDS) bits cleared.
  - Beat k presents mem[(base+k) mod MEM_WORDS]; k advances on rsp_valid && rsp_ready.
  - rsp_last=1 on beat LINE_WORDS-1; after that handshake go to IDLE.
  - req_ready is high the following cycle; there is no back-to-back acceptance in the same cycle as the last beat.
- WACK:
  - one beat with rsp_valid=1, rsp_write=1, rsp_last=1, rsp_data=0; go to IDLE on handshake.
- Backpressure:
  - while rsp_valid=1 and rsp_ready=0, rsp_data, rsp_last and rsp_write hold stable;
  - rsp_valid never drops without a handshake.
- req_valid while busy is ignored (req_ready=0); the requester holds the request.
- Address aliasing: addresses at or above MEM_WORDS wrap modulo MEM_WORDS, with no error.
- Reset mid-operation:
  - the burst is abandoned with no further beats;
  - a write still in WAIT is never committed.
- Read data comes from the memory state at beat time, so a preceding write's commit is visible.

Optional Feature:
- Macro: MEM_RESP_CRIT_WORD_FIRST_EN.
- Defined: burst starts at the requested word and wraps within the line, beat k = base + ((offset+k) mod LINE_WORDS). rsp_last still marks the LINE_WORDS-th beat.
- Undefined: bursts always start at the line base (offset ignored).

Decomposition:
- Shared package mem_resp_pkg:
  - state enum (IDLE/WAIT/BURST/WACK);
  - word-address width constant (30);
  - default LINE_WORDS and LATENCY constants, also used by `cache`.
- One sub-module, resp_mem_array:
  - MEM_WORDS x 32 storage;
  - combinational read port, synchronous write port with write enable;
  - no reset.

Test Plan:
- Read, defaults: preload words 0x40..0x43 = 0xA0..0xA3, read req_addr=0x41, rsp_ready=1 → beats in cycles 3,4,5,6 with data A0,A1,A2,A3 and rsp_last only on A3. With MEM_RESP_CRIT_WORD_FIRST_EN defined → A1,A2,A3,A0.
- Write then read: write req_addr=0x80, wdata=0xDEADBEEF → ack in cycle 3 with rsp_write=1, rsp_last=1, rsp_data=0. A read of 0x80 then returns 0xDEADBEEF on beat 0.
- Backpressure: drop rsp_ready for 2 cycles at beat 1 → rsp_valid stays 1 and rsp_data holds A1. Burst completes 2 cycles late with 4 total handshakes.
- Busy: assert a second req_valid during WAIT → req_ready=0, not accepted. It is accepted in the cycle after the last-beat handshake.
- Reset mid-operation: assert rst=0 during BURST beat 2 → rsp_valid=0 immediately, req_ready=1. Reset during a write's WAIT → the word remains at its old value.
- Aliasing: read req_addr=MEM_WORDS+0x41 → same data as req_addr=0x41.
